core_run_ctrl: RTL

//  Host-side sequencer for the 4-thread barrel datapath. It accepts one host command at a time over a valid/ready interface.

---
 rtl/core_run_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: host-side sequencer for the 4-thread barrel datapath.
// Takes one host command at a time (write I-mem, write D-mem, read D-mem, run).
// It is the only driver of the datapath loader pins, pc_en and core reset.
// A run holds the core in reset, enables fetch for a cycle budget, then drains.
module core_run_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int DRAIN      = 4,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        busy,
  input  logic        abort,
  output logic [31:0] i_mem_addra,
  output logic [31:0] i_mem_din,
  output logic        i_mem_we,
  output logic [7:0]  d_mem_addra,
  output logic [63:0] d_mem_din,
  output logic        d_mem_we,
  input  logic [63:0] d_mem_out,
  output logic        pc_en,
  output logic        core_reset_n
);

  localparam int TMR_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_I,
    S_WR_D,
    S_RD_A,
    S_RD_W,
    S_RSP,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [8:0]         addr_reg;
  logic [63:0]        data_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [TMR_W-1:0]   tmr_reg;
  logic               cmd_ready_reg;
  logic               busy_reg;
  logic               rsp_valid_reg;
  logic [63:0]        rsp_data_reg;
  logic               i_mem_we_reg;
  logic               d_mem_we_reg;
  logic               pc_en_reg;
  logic               core_reset_n_reg;

  logic [CNT_W-1:0]   budget;
  logic [CNT_W-1:0]   budget_m1;

  // The run budget lives in the low bits of the captured command data.
  assign budget    = data_reg[CNT_W-1:0];
  assign budget_m1 = budget - CNT_W'(1);

  // Loader buses come straight from the captured command registers.
  assign i_mem_addra  = {23'd0, addr_reg};
  assign i_mem_din    = data_reg[31:0];
  assign d_mem_addra  = addr_reg[7:0];
  assign d_mem_din    = data_reg;

  assign cmd_ready    = cmd_ready_reg;
  assign busy         = busy_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign i_mem_we     = i_mem_we_reg;
  assign d_mem_we     = d_mem_we_reg;
  assign pc_en        = pc_en_reg;
  assign core_reset_n = core_reset_n_reg;

  // Sequencer FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      addr_reg         <= '0;
      data_reg         <= '0;
      cnt_reg          <= '0;
      tmr_reg          <= '0;
      cmd_ready_reg    <= 1'b1;
      busy_reg         <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_data_reg     <= '0;
      i_mem_we_reg     <= 1'b0;
      d_mem_we_reg     <= 1'b0;
      pc_en_reg        <= 1'b0;
      core_reset_n_reg <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      i_mem_we_reg  <= 1'b0;
      d_mem_we_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            addr_reg      <= cmd_addr;
            data_reg      <= cmd_data;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            case (cmd_op)
              2'd0: begin
                state_reg    <= S_WR_I;
                i_mem_we_reg <= 1'b1;
              end
              2'd1: begin
                state_reg    <= S_WR_D;
                d_mem_we_reg <= 1'b1;
              end
              2'd2: begin
                state_reg <= S_RD_A;
              end
              2'd3: begin
                state_reg <= S_RST;
                cnt_reg   <= '0;
                tmr_reg   <= TMR_W'(RST_CYCLES - 1);
              end
            endcase
          end
        end

        S_WR_I, S_WR_D: begin
          state_reg     <= S_IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end

        // Address has been on the port for a cycle; BRAM output is valid in RD_W.
        S_RD_A: begin
          state_reg <= S_RD_W;
        end

        S_RD_W: begin
          state_reg     <= S_RSP;
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= d_mem_out;
        end

        S_RSP: begin
          state_reg     <= S_IDLE;
          rsp_data_reg  <= '0;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end

        S_RST: begin
          if (tmr_reg == '0) begin
            core_reset_n_reg <= 1'b1;
            if (budget == '0) begin
              state_reg <= S_DRAIN;
              tmr_reg   <= TMR_W'(DRAIN - 1);
            end else begin
              state_reg <= S_RUN;
              pc_en_reg <= 1'b1;
            end
          end else begin
            tmr_reg <= tmr_reg - TMR_W'(1);
          end
        end

        // Counter counts issued pc_en cycles; equality stop means it never wraps.
        S_RUN: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if ((cnt_reg == budget_m1) || abort) begin
            state_reg <= S_DRAIN;
            pc_en_reg <= 1'b0;
            tmr_reg   <= TMR_W'(DRAIN - 1);
          end
        end

        S_DRAIN: begin
          if (tmr_reg == '0) begin
            state_reg     <= S_DONE;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= 64'(cnt_reg);
          end else begin
            tmr_reg <= tmr_reg - TMR_W'(1);
          end
        end

        S_DONE: begin
          state_reg        <= S_IDLE;
          core_reset_n_reg <= 1'b0;
          rsp_data_reg     <= '0;
          cmd_ready_reg    <= 1'b1;
          busy_reg         <= 1'b0;
        end

        default: begin
          state_reg        <= S_IDLE;
          pc_en_reg        <= 1'b0;
          core_reset_n_reg <= 1'b0;
          cmd_ready_reg    <= 1'b1;
          busy_reg         <= 1'b0;
        end
      endcase
    end
  end

endmodule
